// File: rtl/bw_r_irf_window_seq.sv
// Per-thread active register file backed by a window store, with a
// save/restore/swap sequencer driven through a valid/ready command port.
module bw_r_irf_window_seq #(
  parameter int WIDTH = 72,
  parameter int THR_W = 2,
  parameter int WIN_W = 3
) (
  input  logic                          clk,
  input  logic                          arst_l,
  input  logic [(2**THR_W)-1:0]         wren,
  input  logic [(2**THR_W)*WIDTH-1:0]   wr_data,
  input  logic [THR_W-1:0]              rd_thread,
  output logic [WIDTH-1:0]              rd_data,
  input  logic                          cmd_vld,
  output logic                          cmd_rdy,
  input  logic [1:0]                    cmd_op,
  input  logic [THR_W-1:0]              cmd_thr,
  input  logic [WIN_W-1:0]              cmd_win_sv,
  input  logic [WIN_W-1:0]              cmd_win_rs,
  output logic                          done,
  output logic [THR_W-1:0]              done_thr
);
  localparam int NTHR  = 2**THR_W;
  localparam int DEPTH = NTHR * (2**WIN_W);
  localparam logic [1:0] OP_SAVE    = 2'b00;
  localparam logic [1:0] OP_RESTORE = 2'b01;
  localparam logic [1:0] OP_SWAP    = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, LOAD} state_t;

  state_t                 state_reg, state_next;
  logic                   ready_reg;
  logic                   done_reg, done_next;
  logic [THR_W-1:0]       done_thr_reg;
  logic [1:0]             op_reg;
  logic [THR_W-1:0]       thr_reg;
  logic [WIN_W-1:0]       win_sv_reg, win_rs_reg;
  logic [WIDTH-1:0]       sbuf_reg;
  logic [WIDTH-1:0]       rdat_reg;
  logic [WIDTH-1:0]       active_reg [NTHR];
  logic [WIDTH-1:0]       store_mem  [DEPTH];
  logic                   accept, accept_op;

  assign cmd_rdy   = (state_reg == IDLE) && ready_reg;
  assign accept    = cmd_vld && cmd_rdy;
  assign accept_op = accept && (cmd_op != OP_RSVD);
  assign rd_data   = active_reg[rd_thread];
  assign done      = done_reg;
  assign done_thr  = done_thr_reg;

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: if (accept_op) state_next = XFER;
      XFER: begin
        if (op_reg == OP_SAVE) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // ready_reg holds cmd_rdy low for the first cycle after reset release
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_reg    <= IDLE;
      ready_reg    <= 1'b0;
      done_reg     <= 1'b0;
      done_thr_reg <= '0;
      op_reg       <= OP_SAVE;
      thr_reg      <= '0;
      win_sv_reg   <= '0;
      win_rs_reg   <= '0;
      sbuf_reg     <= '0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b1;
      done_reg  <= done_next;
      if (done_next) done_thr_reg <= thr_reg;
      if (accept_op) begin
        op_reg     <= cmd_op;
        thr_reg    <= cmd_thr;
        win_sv_reg <= cmd_win_sv;
        win_rs_reg <= cmd_win_rs;
        sbuf_reg   <= active_reg[cmd_thr];
      end
    end
  end

  // Window store: plain RAM, no reset; same-window swap bypasses the read
  always_ff @(posedge clk) begin
    if (state_reg == XFER) begin
      if (op_reg != OP_RESTORE)
        store_mem[{thr_reg, win_sv_reg}] <= sbuf_reg;
      if ((op_reg == OP_SWAP) && (win_sv_reg == win_rs_reg))
        rdat_reg <= sbuf_reg;
      else
        rdat_reg <= store_mem[{thr_reg, win_rs_reg}];
    end
  end

  // A restore load takes priority over the pipeline write to the same thread
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int i = 0; i < NTHR; i++) active_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NTHR; i++) begin
        if ((state_reg == LOAD) && (thr_reg == THR_W'(i)))
          active_reg[i] <= rdat_reg;
        else if (wren[i])
          active_reg[i] <= wr_data[i*WIDTH +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_bw_r_irf_window_seq.sv
// Scenario bench for bw_r_irf_window_seq: expected done threads are queued
// when a command is issued and popped when the completion pulse appears.
module tb_bw_r_irf_window_seq;
  localparam int WIDTH = 72;
  localparam int THR_W = 2;
  localparam int WIN_W = 3;
  localparam int NTHR  = 4;

  logic                    clk = 1'b0;
  logic                    arst_l;
  logic [NTHR-1:0]         wren;
  logic [NTHR*WIDTH-1:0]   wr_data;
  logic [THR_W-1:0]        rd_thread;
  logic [WIDTH-1:0]        rd_data;
  logic                    cmd_vld;
  logic                    cmd_rdy;
  logic [1:0]              cmd_op;
  logic [THR_W-1:0]        cmd_thr;
  logic [WIN_W-1:0]        cmd_win_sv;
  logic [WIN_W-1:0]        cmd_win_rs;
  logic                    done;
  logic [THR_W-1:0]        done_thr;

  int total = 0;
  int bad   = 0;
  logic [THR_W-1:0] exp_q [$];

  bw_r_irf_window_seq #(.WIDTH(WIDTH), .THR_W(THR_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .arst_l(arst_l), .wren(wren), .wr_data(wr_data),
    .rd_thread(rd_thread), .rd_data(rd_data), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_thr(cmd_thr),
    .cmd_win_sv(cmd_win_sv), .cmd_win_rs(cmd_win_rs),
    .done(done), .done_thr(done_thr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Starts and ends at a falling edge.
  task automatic wr(input int t, input logic [WIDTH-1:0] d);
    wren[t] = 1'b1;
    wr_data[t*WIDTH +: WIDTH] = d;
    @(posedge clk);
    #1 wren = '0;
    @(negedge clk);
  endtask

  // Issues one command; returns cycles from acceptance to done (or got=0).
  task automatic issue(input logic [1:0] op, input logic [THR_W-1:0] thr,
                       input logic [WIN_W-1:0] sv, input logic [WIN_W-1:0] rs,
                       input bit exp_done, output int lat,
                       output logic [THR_W-1:0] dthr, output bit got);
    int n;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_vld = 1'b1; cmd_op = op; cmd_thr = thr; cmd_win_sv = sv; cmd_win_rs = rs;
    if (exp_done) exp_q.push_back(thr);
    @(posedge clk);
    #1 cmd_vld = 1'b0;
    got = 1'b0; lat = 0; dthr = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        got  = 1'b1;
        dthr = done_thr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int t = 0; t < NTHR; t++) wr(t, WIDTH'(t + 1));
    @(posedge clk);
    #3 arst_l = 1'b0;
    for (int t = 0; t < NTHR; t++) begin
      rd_thread = THR_W'(t);
      #1;
      total++;
      if (rd_data !== '0) begin
        bad++; $display("FAIL reset_active thr=%0d got=%h exp=0", t, rd_data);
      end
    end
    total++;
    if (cmd_rdy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got rdy=%b done=%b exp rdy=0 done=0", cmd_rdy, done);
    end
    @(negedge clk) arst_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++; $display("FAIL reset_release_rdy got=%b exp=1", cmd_rdy);
    end
    $display("test_reset done");
  endtask

  task automatic test_save_restore();
    int lat; logic [THR_W-1:0] dthr, e; bit got;
    wr(2, 72'hA5);
    issue(2'b00, 2'd2, 3'd5, 3'd0, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    total++;
    if (!got || lat != 2 || dthr !== e) begin
      bad++; $display("FAIL save got=%0b lat=%0d thr=%0d exp lat=2 thr=%0d", got, lat, dthr, e);
    end
    wr(2, 72'h3C);
    rd_thread = 2'd2; #1;
    total++;
    if (rd_data !== 72'h3C) begin
      bad++; $display("FAIL pipe_write got=%h exp=3c", rd_data);
    end
    issue(2'b01, 2'd2, 3'd0, 3'd5, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd2; #1;
    total++;
    if (!got || lat != 3 || dthr !== e || rd_data !== 72'hA5) begin
      bad++; $display("FAIL restore got=%0b lat=%0d thr=%0d data=%h exp lat=3 thr=%0d data=a5",
                      got, lat, dthr, rd_data, e);
    end
    $display("test_save_restore done");
  endtask

  task automatic test_swap();
    int lat; logic [THR_W-1:0] dthr, e; bit got;
    wr(1, 72'h22);
    issue(2'b00, 2'd1, 3'd3, 3'd0, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    wr(1, 72'h11);
    issue(2'b10, 2'd1, 3'd0, 3'd3, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd1; #1;
    total++;
    if (!got || lat != 3 || dthr !== e || rd_data !== 72'h22) begin
      bad++; $display("FAIL swap got=%0b lat=%0d thr=%0d data=%h exp lat=3 thr=%0d data=22",
                      got, lat, dthr, rd_data, e);
    end
    issue(2'b01, 2'd1, 3'd0, 3'd0, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd1; #1;
    total++;
    if (!got || dthr !== e || rd_data !== 72'h11) begin
      bad++; $display("FAIL swap_saved got=%0b thr=%0d data=%h exp thr=%0d data=11", got, dthr, rd_data, e);
    end
    $display("test_swap done");
  endtask

  task automatic test_swap_same();
    int lat; logic [THR_W-1:0] dthr, e; bit got;
    wr(0, 72'h77);
    issue(2'b10, 2'd0, 3'd6, 3'd6, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd0; #1;
    total++;
    if (!got || dthr !== e || rd_data !== 72'h77) begin
      bad++; $display("FAIL swap_same got=%0b thr=%0d data=%h exp thr=%0d data=77", got, dthr, rd_data, e);
    end
    wr(0, 72'h0);
    issue(2'b01, 2'd0, 3'd0, 3'd6, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd0; #1;
    total++;
    if (!got || dthr !== e || rd_data !== 72'h77) begin
      bad++; $display("FAIL swap_same_store got=%0b thr=%0d data=%h exp thr=%0d data=77", got, dthr, rd_data, e);
    end
    $display("test_swap_same done");
  endtask

  task automatic test_collision();
    int lat; logic [THR_W-1:0] dthr, e; bit got;
    wr(1, 72'h55);
    issue(2'b00, 2'd1, 3'd2, 3'd0, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    wr(1, 72'h0);
    fork
      issue(2'b01, 2'd1, 3'd0, 3'd2, 1'b1, lat, dthr, got);
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        wren = 4'b0011;
        wr_data[1*WIDTH +: WIDTH] = 72'hFF;
        wr_data[0*WIDTH +: WIDTH] = 72'h9;
        @(posedge clk);
        #1 wren = '0;
      end
    join
    e = exp_q.pop_front();
    rd_thread = 2'd1; #1;
    total++;
    if (!got || dthr !== e || rd_data !== 72'h55) begin
      bad++; $display("FAIL collision_thr1 got=%0b thr=%0d data=%h exp thr=%0d data=55", got, dthr, rd_data, e);
    end
    rd_thread = 2'd0; #1;
    total++;
    if (rd_data !== 72'h9) begin
      bad++; $display("FAIL collision_thr0 got=%h exp=9", rd_data);
    end
    $display("test_collision done");
  endtask

  task automatic test_back_to_back();
    int lat; logic [THR_W-1:0] dthr, e; bit got;
    wr(3, 72'hBEEF);
    issue(2'b00, 2'd3, 3'd4, 3'd0, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    issue(2'b01, 2'd3, 3'd0, 3'd4, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd3; #1;
    total++;
    if (!got || lat != 3 || dthr !== e || rd_data !== 72'hBEEF) begin
      bad++; $display("FAIL back_to_back got=%0b lat=%0d thr=%0d data=%h exp lat=3 thr=%0d data=beef",
                      got, lat, dthr, rd_data, e);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_load();
    int lat; logic [THR_W-1:0] dthr, e; bit got;
    wr(3, 72'hAB);
    issue(2'b00, 2'd3, 3'd1, 3'd0, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    wr(3, 72'hCD);
    fork
      issue(2'b01, 2'd3, 3'd0, 3'd1, 1'b0, lat, dthr, got);
      begin
        @(posedge clk);
        @(posedge clk);
        #2 arst_l = 1'b0;
        rd_thread = 2'd3; #1;
        total++;
        if (rd_data !== '0) begin
          bad++; $display("FAIL reset_load_clear got=%h exp=0", rd_data);
        end
        @(negedge clk) arst_l = 1'b1;
      end
    join
    rd_thread = 2'd3; #1;
    total++;
    if (got || rd_data !== '0) begin
      bad++; $display("FAIL reset_load_abort done=%0b data=%h exp done=0 data=0", got, rd_data);
    end
    issue(2'b01, 2'd3, 3'd0, 3'd1, 1'b1, lat, dthr, got);
    e = exp_q.pop_front();
    rd_thread = 2'd3; #1;
    total++;
    if (!got || dthr !== e || rd_data !== 72'hAB) begin
      bad++; $display("FAIL reset_load_store got=%0b thr=%0d data=%h exp thr=%0d data=ab", got, dthr, rd_data, e);
    end
    $display("test_reset_load done");
  endtask

  task automatic test_reserved();
    bit seen;
    rd_thread = 2'd2; #1;
    cmd_vld = 1'b1; cmd_op = 2'b11; cmd_thr = 2'd2; cmd_win_sv = 3'd5; cmd_win_rs = 3'd5;
    @(posedge clk);
    #1 cmd_vld = 1'b0;
    total++;
    if (cmd_rdy !== 1'b1) begin
      bad++; $display("FAIL reserved_rdy got=%b exp=1", cmd_rdy);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (seen || rd_data !== 72'hA5 || cmd_rdy !== 1'b1) begin
      bad++; $display("FAIL reserved_effect done_seen=%0b data=%h rdy=%b exp 0/a5/1", seen, rd_data, cmd_rdy);
    end
    $display("test_reserved done");
  endtask

  initial begin
    arst_l = 1'b0; wren = '0; wr_data = '0; rd_thread = '0;
    cmd_vld = 1'b0; cmd_op = '0; cmd_thr = '0; cmd_win_sv = '0; cmd_win_rs = '0;
    repeat (2) @(negedge clk);
    arst_l = 1'b1;
    @(negedge clk);
    test_reset();
    test_save_restore();
    test_swap();
    test_swap_same();
    test_collision();
    test_back_to_back();
    test_reserved();
    test_reset_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
